// File: rtl/winograd_conv_stream_if.sv
// Image-in and result-out valid/ready streams of winograd_conv_stream.
// The engine side uses the slave modport; the producer/consumer uses master.
interface winograd_conv_stream_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W+8,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_row, out_col);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_row, out_col);
endinterface

// File: rtl/winograd_conv_stream.sv
// Streaming Winograd F(2x2,3x3) valid convolution: buffer the image, then XFORM/MUL/INV/EMIT per 4x4 tile.
// Optional build macro WINOGRAD_RELU_EN clamps negative results to zero in the INV stage.
module winograd_conv_stream #(
  parameter int IMG_ROWS = 10,
  parameter int IMG_COLS = 12,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 2*DATA_W+8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [0:2][0:2][DATA_W-1:0] kernel_in,
  output logic                        busy,
  output logic                        done,
  winograd_conv_stream_if.slave       bus
);
  localparam int ROW_W = $clog2(IMG_ROWS);
  localparam int COL_W = $clog2(IMG_COLS);
  localparam int NPIX  = IMG_ROWS*IMG_COLS;
  localparam int PIX_W = $clog2(NPIX);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic [2:0] {IDLE, LOAD, XFORM, MUL, INV, EMIT, FINISH} state_t;

  state_t            state, state_nx;
  logic [PIX_W-1:0]  pix_cnt;
  logic [ROW_W-1:0]  tile_r0;
  logic [COL_W-1:0]  tile_c0;
  logic [3:0]        pend;
  logic [3:0]        pend_init, pend_left;
  logic [1:0]        sel;
  logic              last_pix, last_tile;

  logic [DATA_W-1:0] img [NPIX];
  acc_t u [4][4];
  acc_t v [4][4];
  acc_t m [4][4];
  acc_t y [2][2];
  acc_t gk [4][3];
  acc_t u_nx [4][4];
  acc_t d [4][4];
  acc_t bd [4][4];
  acc_t v_nx [4][4];
  acc_t am [2][4];
  acc_t y_nx [2][2];

  function automatic acc_t sx(input logic [DATA_W-1:0] x);
    return acc_t'($signed(x));
  endfunction

  // U = G'.g.G'^T with G' = 2G, so U carries a factor of 4 removed in INV.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      gk[0][j] = sx(kernel_in[0][j]) + sx(kernel_in[0][j]);
      gk[1][j] = sx(kernel_in[0][j]) + sx(kernel_in[1][j]) + sx(kernel_in[2][j]);
      gk[2][j] = sx(kernel_in[0][j]) - sx(kernel_in[1][j]) + sx(kernel_in[2][j]);
      gk[3][j] = sx(kernel_in[2][j]) + sx(kernel_in[2][j]);
    end
    for (int i = 0; i < 4; i++) begin
      u_nx[i][0] = gk[i][0] + gk[i][0];
      u_nx[i][1] = gk[i][0] + gk[i][1] + gk[i][2];
      u_nx[i][2] = gk[i][0] - gk[i][1] + gk[i][2];
      u_nx[i][3] = gk[i][2] + gk[i][2];
    end
  end

  // V = B^T.d.B over the current tile; pixels past the image edge read as zero.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        d[r][c] = '0;
        if (int'(tile_r0) + r < IMG_ROWS && int'(tile_c0) + c < IMG_COLS)
          d[r][c] = sx(img[PIX_W'((int'(tile_r0) + r)*IMG_COLS + int'(tile_c0) + c)]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      bd[0][j] = d[0][j] - d[2][j];
      bd[1][j] = d[1][j] + d[2][j];
      bd[2][j] = d[2][j] - d[1][j];
      bd[3][j] = d[1][j] - d[3][j];
    end
    for (int i = 0; i < 4; i++) begin
      v_nx[i][0] = bd[i][0] - bd[i][2];
      v_nx[i][1] = bd[i][1] + bd[i][2];
      v_nx[i][2] = bd[i][2] - bd[i][1];
      v_nx[i][3] = bd[i][1] - bd[i][3];
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      am[0][j] = m[0][j] + m[1][j] + m[2][j];
      am[1][j] = m[1][j] - m[2][j] - m[3][j];
    end
    for (int i = 0; i < 2; i++) begin
      y_nx[i][0] = (am[i][0] + am[i][1] + am[i][2]) >>> 2;
      y_nx[i][1] = (am[i][1] - am[i][2] - am[i][3]) >>> 2;
`ifdef WINOGRAD_RELU_EN
      for (int j = 0; j < 2; j++)
        if (y_nx[i][j] < 0) y_nx[i][j] = '0;
`endif
    end
  end

  // Tile results that fall past the valid output region are never presented.
  always_comb begin
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        pend_init[r*2+c] = (int'(tile_r0) + r < IMG_ROWS-2) && (int'(tile_c0) + c < IMG_COLS-2);
    sel       = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
    pend_left = pend & ~(4'b0001 << sel);
    last_pix  = (pix_cnt == PIX_W'(NPIX-1));
    last_tile = (int'(tile_r0) + 2 >= IMG_ROWS-2) && (int'(tile_c0) + 2 >= IMG_COLS-2);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_row   = '0;
    bus.out_col   = '0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && last_pix) state_nx = XFORM;
      end
      XFORM: state_nx = MUL;
      MUL:   state_nx = INV;
      INV:   state_nx = EMIT;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = y[sel[1]][sel[0]];
        bus.out_row   = tile_r0 + ROW_W'(sel[1]);
        bus.out_col   = tile_c0 + COL_W'(sel[0]);
        if (bus.out_ready && pend_left == '0) state_nx = last_tile ? FINISH : XFORM;
      end
      FINISH: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pix_cnt <= '0;
      tile_r0 <= '0;
      tile_c0 <= '0;
      pend    <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          pix_cnt <= '0;
          tile_r0 <= '0;
          tile_c0 <= '0;
        end
        LOAD: if (bus.in_valid) pix_cnt <= pix_cnt + 1'b1;
        INV:  pend <= pend_init;
        EMIT: if (bus.out_ready) begin
          pend <= pend_left;
          if (pend_left == '0 && !last_tile) begin
            if (int'(tile_c0) + 2 >= IMG_COLS-2) begin
              tile_c0 <= '0;
              tile_r0 <= tile_r0 + ROW_W'(2);
            end else begin
              tile_c0 <= tile_c0 + COL_W'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the image buffer and datapath are left unreset; control state alone decides when they are read.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) u <= u_nx;
    if (state == LOAD && bus.in_valid) img[pix_cnt] <= bus.in_data;
    if (state == XFORM) v <= v_nx;
    if (state == MUL)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          m[i][j] <= u[i][j] * v[i][j];
    if (state == INV) y <= y_nx;
  end
endmodule

// File: tb/tb_winograd_conv_stream.sv
// Self-checking bench for winograd_conv_stream: a 10x12 and a 5x5 instance share stimulus;
// a direct-convolution model fills a scoreboard queue that is drained at each output handshake.
`timescale 1ns/1ps
module tb_winograd_conv_stream;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 2*DATA_W+8;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct {
    int   row;
    int   col;
    acc_t data;
  } res_t;

  typedef struct {
    bit   sel;         // 0: 10x12 instance, 1: 5x5 instance
    int   img_mode;    // 0: i*cols+j+1, 1: all ones
    int   ker_mode;    // 0: 1..9, 1: all -1, 2: alternate
    bit   gaps;
    int   stall_at;    // hold out_ready low 5 cycles after this many results (0 = never)
    bit   busy_start;
    int   exp_count;
    acc_t exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start_a, start_b, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [0:2][0:2][DATA_W-1:0] kernel;
  logic busy_a, busy_b, done_a, done_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];
  acc_t res_a [8][10];
  vec_t tbl [5];

  winograd_conv_stream_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(4), .COL_W(4)) if_a ();
  winograd_conv_stream_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(3), .COL_W(3)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.out_ready = out_ready;

  winograd_conv_stream #(.IMG_ROWS(10), .IMG_COLS(12), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .kernel_in(kernel),
    .busy(busy_a), .done(done_a), .bus(if_a));

  winograd_conv_stream #(.IMG_ROWS(5), .IMG_COLS(5), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .kernel_in(kernel),
    .busy(busy_b), .done(done_b), .bus(if_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  function automatic logic m_valid(input bit s); return s ? if_b.out_valid : if_a.out_valid; endfunction
  function automatic logic m_in_ready(input bit s); return s ? if_b.in_ready : if_a.in_ready; endfunction
  function automatic logic m_busy(input bit s); return s ? busy_b : busy_a; endfunction
  function automatic logic m_done(input bit s); return s ? done_b : done_a; endfunction
  function automatic acc_t m_data(input bit s); return s ? acc_t'(if_b.out_data) : acc_t'(if_a.out_data); endfunction
  function automatic int m_row(input bit s); return s ? int'(if_b.out_row) : int'(if_a.out_row); endfunction
  function automatic int m_col(input bit s); return s ? int'(if_b.out_col) : int'(if_a.out_col); endfunction

  task automatic check(input string name, input acc_t act, input acc_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix(input bit s, input int mode, input int i, input int j);
    if (mode == 1) return 1;
    return i*(s ? 5 : 12) + j + 1;
  endfunction

  function automatic int ker(input int mode, input int a, input int b);
    case (mode)
      0:       return 3*a + b + 1;
      1:       return -1;
      default: return 10 - 2*(3*a + b);
    endcase
  endfunction

  task automatic set_kernel(input int mode);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        kernel[a][b] = DATA_W'(ker(mode, a, b));
  endtask

  // Direct convolution, emitted in tile order (2x2 blocks row-major, tiles row-major).
  task automatic model_job(input bit s, input int im, input int km);
    int rows, cols;
    rows = s ? 5 : 10;
    cols = s ? 5 : 12;
    for (int tr = 0; tr < rows-2; tr += 2)
      for (int tc = 0; tc < cols-2; tc += 2)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            if (tr+r < rows-2 && tc+c < cols-2) begin
              longint sum = 0;
              for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                  sum += longint'(pix(s, im, tr+r+a, tc+c+b)) * longint'(ker(km, a, b));
`ifdef WINOGRAD_RELU_EN
              if (sum < 0) sum = 0;
`endif
              sb.push_back('{tr+r, tc+c, acc_t'(sum)});
            end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_in_ready"}, acc_t'(if_a.in_ready), 0);
    check({tag, "_out_valid"}, acc_t'(if_a.out_valid), 0);
    check({tag, "_out_data"}, acc_t'(if_a.out_data), 0);
    check({tag, "_out_rowcol"}, acc_t'({if_a.out_row, if_a.out_col}), 0);
    check({tag, "_busy"}, acc_t'(busy_a), 0);
    check({tag, "_done"}, acc_t'(done_a), 0);
  endtask

  task automatic run_job(input vec_t v);
    int   rows, cols, npix, tiles, n_res, n_done, done_at;
    rows    = v.sel ? 5 : 10;
    cols    = v.sel ? 5 : 12;
    npix    = rows*cols;
    tiles   = ((rows-1)/2) * ((cols-1)/2);
    n_res   = 0;
    n_done  = 0;
    done_at = -1;
    sb.delete();
    model_job(v.sel, v.img_mode, v.ker_mode);
    set_kernel(v.ker_mode);
    fork
      begin : drive
        int idx;
        idx = 0;
        @(negedge clk);
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_rise", acc_t'(m_busy(v.sel)), 1);
        check("in_ready_rise", acc_t'(m_in_ready(v.sel)), 1);
        for (int cyc = 0; cyc < 4*npix + 20 && idx < npix; cyc++) begin
          if (v.busy_start && idx == 5) begin
            set_kernel(2);
            if (v.sel) start_b = 1'b1; else start_a = 1'b1;
          end else begin
            start_a = 1'b0;
            start_b = 1'b0;
          end
          in_valid = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          in_data  = DATA_W'(pix(v.sel, v.img_mode, idx / cols, idx % cols));
          if (in_valid && m_in_ready(v.sel)) idx++;
          @(negedge clk);
        end
        in_valid = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        check("load_words", acc_t'(idx), acc_t'(npix));
      end
      begin : monitor
        bit   hold;
        int   stall_left, hs;
        res_t held, exp;
        hold       = 1'b0;
        stall_left = 0;
        hs         = 0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 4000; cyc++) begin
          @(negedge clk);
          if (m_done(v.sel)) begin
            n_done++;
            if (done_at < 0) begin
              done_at = cyc;
              check("busy_at_done", acc_t'(m_busy(v.sel)), 0);
            end
          end
          if (done_at >= 0 && cyc >= done_at + 6) break;
          if (hold) begin
            check("hold_valid", acc_t'(m_valid(v.sel)), 1);
            check("hold_data", m_data(v.sel), held.data);
            check("hold_pos", acc_t'(m_row(v.sel)*16 + m_col(v.sel)), acc_t'(held.row*16 + held.col));
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
          hold = 1'b0;
          if (m_valid(v.sel)) begin
            if (out_ready) begin
              if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_result: got (%0d,%0d)=%0d, expected none",
                         m_row(v.sel), m_col(v.sel), m_data(v.sel));
              end else begin
                exp = sb.pop_front();
                check("result_pos", acc_t'(m_row(v.sel)*16 + m_col(v.sel)), acc_t'(exp.row*16 + exp.col));
                check("result_data", m_data(v.sel), exp.data);
                if (n_res == 0) check("first_result", m_data(v.sel), v.exp_first);
                if (!v.sel && m_row(v.sel) < 8 && m_col(v.sel) < 10)
                  res_a[m_row(v.sel)][m_col(v.sel)] = m_data(v.sel);
              end
              n_res++;
              hs++;
              if (hs == v.stall_at) stall_left = 5;
            end else begin
              hold = 1'b1;
              held = '{m_row(v.sel), m_col(v.sel), m_data(v.sel)};
            end
          end
        end
        out_ready = 1'b0;
      end
    join
    check("result_count", acc_t'(n_res), acc_t'(v.exp_count));
    check("done_pulses", acc_t'(n_done), 1);
    check("sb_left", acc_t'(sb.size()), 0);
    if (!v.gaps && v.stall_at == 0)
      check("latency", acc_t'(done_at + 1), acc_t'(npix + tiles*3 + (rows-2)*(cols-2) + 2));
    if (!v.sel && v.img_mode == 0 && v.ker_mode == 0) begin
      check("res_0_1", res_a[0][1], 897);
      check("res_1_0", res_a[1][0], 1392);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 0, 0, 1'b0, 0,  1'b0, 80, acc_t'(852)};
    tbl[1] = '{1'b1, 0, 0, 1'b0, 0,  1'b0, 9,  acc_t'(411)};
    tbl[2] = '{1'b0, 0, 0, 1'b1, 10, 1'b0, 80, acc_t'(852)};
`ifdef WINOGRAD_RELU_EN
    tbl[3] = '{1'b0, 1, 1, 1'b0, 0,  1'b0, 80, acc_t'(0)};
`else
    tbl[3] = '{1'b0, 1, 1, 1'b0, 0,  1'b0, 80, acc_t'(-9)};
`endif
    tbl[4] = '{1'b0, 0, 0, 1'b0, 0,  1'b1, 80, acc_t'(852)};

    rst       = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    set_kernel(0);
    repeat (2) @(negedge clk);
    check_idle_a("reset");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) run_job(tbl[t]);

    // rst and start in the same cycle: reset wins.
    @(negedge clk);
    rst     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    check("rst_start_busy", acc_t'(busy_a), 0);

    // Reset in the middle of LOAD after 37 accepted words, then a fresh full job.
    set_kernel(0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int cyc = 0; cyc < 200 && idx < 37; cyc++) begin
        in_valid = 1'b1;
        in_data  = DATA_W'(pix(1'b0, 0, idx / 12, idx % 12));
        if (if_a.in_ready) idx++;
        @(negedge clk);
      end
      check("mid_load_words", acc_t'(idx), 37);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_idle_a("mid_rst");
    rst = 1'b0;
    run_job(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/winograd_conv_stream.md
# winograd_conv_stream

Parametrised streaming Winograd F(2x2,3x3) valid-convolution engine, the successor to the fixed 10x12 array-port convolver in the winograd module group. It accepts an IMG_ROWS x IMG_COLS signed image over a valid/ready stream and a 3x3 kernel sampled on `start`. It computes the (IMG_ROWS-2) x (IMG_COLS-2) result tile by tile and emits each result with its coordinates over a second valid/ready stream.

## Interface
- IMG_ROWS, 10, image rows (>= 3)
- IMG_COLS, 12, image columns (>= 3)
- DATA_W, 32, signed pixel/kernel width
- ACC_W, 2*DATA_W+8, internal and output width (>= 2*DATA_W+8)
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- kernel_in[0:2][0:2]  in  DATA_W each  signed kernel, sampled on accepted start
- in_valid  in  1  image word valid
- in_ready  out  1  engine accepts an image word
- in_data  in  DATA_W  signed pixel, row-major order
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts the result
- out_data  out  ACC_W  signed result
- out_row  out  $clog2(IMG_ROWS)  result row index
- out_col  out  $clog2(IMG_COLS)  result column index
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last result handshake

## Operation
- States: IDLE -> LOAD -> XFORM -> MUL -> INV -> EMIT -> (XFORM for the next tile | FINISH) -> IDLE.
- IDLE: on `start`, register G'·g·G'^T. G' = [[2,0,0],[1,1,1],[1,-1,1],[0,0,2]] (2G, so there is no division). Clear the pixel counter, set busy, go to LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready handshake writes one pixel into an IMG_ROWS*IMG_COLS buffer. After word IMG_ROWS*IMG_COLS-1, go to XFORM with tile (0,0).
- Tiles: tile (ti,tj) covers image rows 2ti..2ti+3 and columns 2tj..2tj+3. Pixels outside the image read as 0. Tiles run row-major over ceil((IMG_ROWS-2)/2) x ceil((IMG_COLS-2)/2) tiles.
- XFORM: register V = B^T·d·B with B^T = [[1,0,-1,0],[0,1,1,0],[0,-1,1,0],[0,1,0,-1]].
- MUL: register M = U ⊙ V (16 products, ACC_W).
- INV: register Y = (A^T·M·A) >>> 2, with A^T = [[1,1,1,0],[0,1,-1,-1]]. The shift is exact, because G' scales U by 4.
- EMIT: present the 4 tile results row-major. Skip any result with row >= IMG_ROWS-2 or col >= IMG_COLS-2. Advance only on out_valid&&out_ready.
- FINISH: pulse done for one cycle, clear busy, return to IDLE.
- Arithmetic: two's complement, computed in ACC_W. Results wrap on overflow with no saturation.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, done=0, state=IDLE.
- Reset mid-operation: the job is abandoned and outputs return to their reset values on the next edge. Buffer contents are don't-care.
- rst and start asserted in the same cycle: reset wins.
- start while busy: ignored. kernel_in changes after an accepted start: no effect on the current job.
- busy rises the cycle after start. in_ready rises the same cycle busy rises.
- Per tile: 3 cycles (XFORM, MUL, INV), then one cycle per emitted result while out_ready=1.
- While out_valid=1 and out_ready=0, out_data, out_row and out_col are held stable.
- done is asserted the cycle after the final output handshake. busy=0 in that same cycle.
- Minimum job latency: IMG_ROWS*IMG_COLS + tiles*3 + (IMG_ROWS-2)*(IMG_COLS-2) + 2 cycles, with no stalls.

## Configuration
- WINOGRAD_RELU_EN:
  - Defined: out_data = (Y < 0) ? 0 : Y, applied in the INV register stage.
  - Undefined: out_data = Y unchanged.
- Latency and handshakes are identical in both builds.

## Test plan
- Default 10x12 image with pixel[i][j] = i*12+j+1 and kernel 1..9 -> 80 results. (0,0)=852, (0,1)=897, (1,0)=1392. All results match a direct-convolution reference model. done is pulsed once.
- IMG_ROWS=5, IMG_COLS=5 with the same pixel formula -> exactly 9 results, 4 tiles processed, no out_row or out_col >= 3.
- out_ready held low for 5 cycles mid-EMIT, plus random in_valid gaps during LOAD -> outputs stable while stalled. No result is lost or duplicated, and order and values are unchanged.
- Image all 1, kernel all -1 -> every result is -9 without WINOGRAD_RELU_EN and 0 with it.
- Assert rst during LOAD after 37 words, then a fresh start with the full image -> reset values are observed, and the second job produces correct results.
- Pulse start while busy with a different kernel_in -> ignored. Results use the original kernel, and only one done is pulsed.
